adc_mock_ctrl: RTL and testbench
================================

// Module: adc_mock_ctrl
// PURPOSE
//  Behavioural model of a simple parallel ADC, used by SoC benches next to the PULPino/Qsys top.
//  A rising edge on TRIGGER starts one conversion. The result comes from an internal
//  address-indexed pattern source and appears on DATA after a fixed delay, with a DVALID strobe.
//  Bench hooks can force the pattern address or the converted value.
// PARAMETERS
//  DELAY_DEPTH  5           conversion delay in CLK cycles; must be >= 1
//  WORD_SIZE    8           width of DATA and TB_DATA in bits
//  ADDR_DEPTH   WORD_SIZE   pattern address width; the source holds 2**ADDR_DEPTH words
// PORTS
//  CLK            in   1           single clock; all logic on the rising edge
//  RESET          in   1           synchronous, active-high reset
//  TRIGGER        in   1           conversion request; only its rising edge is used
//  DATA           out  WORD_SIZE   last converted word
//  DVALID         out  1           conversion-done strobe
//  BUSY           out  1           high while a conversion is in progress
//  TB_FORCE_ADDR  in   1           load the pattern address from TB_ADDR
//  TB_FORCE_DATA  in   1           replace the sampled word with TB_DATA
//  TB_DATA        in   WORD_SIZE   forced conversion value
//  TB_ADDR        in   ADDR_DEPTH  forced pattern address
// BEHAVIOUR
//  - Reset: DATA=0, DVALID=0, BUSY=0, state=IDLE, address=0, counter=0, trig_q=0.
//  - Edge detect: trig_q <= TRIGGER every cycle; edge = TRIGGER & ~trig_q.
//  - Pattern source: internal instance named fake_adc_data with signals ADDR, ENABLE and DATA.
//    Its DATA is registered: at each clock with ENABLE=1 it loads ADDR ^ {WORD_SIZE{1010_0101 repeated}}.
//    The pattern is truncated or zero-extended to WORD_SIZE. Benches probe these names hierarchically.
//  - FSM states:
//    - IDLE: on edge at clock k -> SAMPLE; BUSY=1 and ENABLE=1 from clock k.
//    - SAMPLE: one cycle. ENABLE drops to 0. sample <= TB_FORCE_DATA ? TB_DATA : fake_adc_data.DATA.
//      Counter loads DELAY_DEPTH-1. Go to CONVERT.
//    - CONVERT: decrement the counter each cycle. At 0: DATA <= sample, DVALID=1, BUSY=0,
//      address += 1, go to IDLE.
//    - DVALID rises DELAY_DEPTH+1 clocks after BUSY rises and lasts one cycle.
//  - Address wraps from 2**ADDR_DEPTH-1 to 0.
//  - TB_FORCE_ADDR=1 loads TB_ADDR in any state. It wins over a same-cycle increment.
//  - TRIGGER edges while BUSY=1 are ignored; they are not queued.
//    A TRIGGER held high does not retrigger; it must fall first.
//  - DATA holds its value between conversions. It changes only at completion or on reset.
//  - RESET mid-conversion aborts: all outputs return to reset values and no DVALID is issued.
//  - TB_FORCE_DATA is sampled only in the SAMPLE state.
// CONFIGURATION
//  ADC_MOCK_DVALID_HOLD_EN
//  - Defined: DVALID stays high from completion until the next accepted trigger edge
//    or reset, level semantics.
//  - Undefined (default): DVALID is a one-cycle pulse.
//  - BUSY and DATA timing are identical in both builds.
// TESTING
//  1. Reset with TRIGGER=0 -> DATA=0, DVALID=0, BUSY=0, fake_adc_data.ADDR=0.
//  2. TRIGGER pulse (ADDR=0, defaults) -> BUSY high 6 cycles; then DATA=8'hA5, DVALID 1 cycle.
//     ADDR becomes 1.
//  3. Second trigger -> DATA=8'hA4. Before completion, fake_adc_data.DATA equals DATA
//     from the clock after ENABLE.
//  4. Trigger again while BUSY -> no extra conversion. Exactly one DVALID; ADDR advances by 1.
//  5. TB_FORCE_ADDR with TB_ADDR=8'hFF, then two triggers -> DATA=8'h5A, then 8'hA5; ADDR wraps to 1.
//  6. TB_FORCE_DATA with TB_DATA=8'h3C -> DATA=8'h3C.
//     RESET asserted in CONVERT -> no DVALID; all outputs 0 on the next clock.

Source files
------------

// File: rtl/adc_mock_ctrl.sv
// Behavioural parallel-ADC mock: TRIGGER rising edge -> sample pattern/forced word -> DATA + DVALID after a fixed delay.
// Optional build macro ADC_MOCK_DVALID_HOLD_EN turns DVALID into a level held until the next accepted trigger.

module adc_mock_pattern #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  ENABLE,
  input  logic [ADDR_DEPTH-1:0] ADDR,
  output logic [WORD_SIZE-1:0]  DATA
);

  localparam logic [7:0] PATTERN_BYTE = 8'hA5;

  // Address resized to the word, then XORed with 0xA5 repeated across the word.
  function automatic logic [WORD_SIZE-1:0] pattern_word(input logic [ADDR_DEPTH-1:0] a);
    logic [WORD_SIZE-1:0] mask;
    logic [WORD_SIZE-1:0] ext;
    for (int i = 0; i < WORD_SIZE; i++) begin
      mask[i] = PATTERN_BYTE[i[2:0]];
    end
    ext = WORD_SIZE'(a);
    return ext ^ mask;
  endfunction

  always_ff @(posedge CLK) begin
    if (ENABLE) begin
      DATA <= pattern_word(ADDR);
    end
  end

endmodule

module adc_mock_ctrl #(
  parameter int DELAY_DEPTH = 5,
  parameter int WORD_SIZE   = 8,
  parameter int ADDR_DEPTH  = WORD_SIZE
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  TRIGGER,
  output logic [WORD_SIZE-1:0]  DATA,
  output logic                  DVALID,
  output logic                  BUSY,
  input  logic                  TB_FORCE_ADDR,
  input  logic                  TB_FORCE_DATA,
  input  logic [WORD_SIZE-1:0]  TB_DATA,
  input  logic [ADDR_DEPTH-1:0] TB_ADDR
);

  localparam int CNT_W = (DELAY_DEPTH > 1) ? $clog2(DELAY_DEPTH) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SAMPLE  = 2'd1;
  localparam logic [1:0] CONVERT = 2'd2;

  logic [1:0]            state;
  logic                  trig_q;
  logic                  trig_edge;
  logic                  enable;
  logic                  done;
  logic [ADDR_DEPTH-1:0] addr;
  logic [CNT_W-1:0]      count;
  logic [WORD_SIZE-1:0]  pattern;
  logic [WORD_SIZE-1:0]  sample;

  assign trig_edge = TRIGGER & ~trig_q;
  // Pattern loads on the accepting edge itself so SAMPLE sees the fresh word.
  assign enable    = (state == IDLE) & trig_edge;
  assign done      = (state == CONVERT) && (count == '0);

  adc_mock_pattern #(
    .WORD_SIZE  (WORD_SIZE),
    .ADDR_DEPTH (ADDR_DEPTH)
  ) fake_adc_data (
    .CLK    (CLK),
    .ENABLE (enable),
    .ADDR   (addr),
    .DATA   (pattern)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      trig_q <= 1'b0;
      BUSY   <= 1'b0;
      DVALID <= 1'b0;
      DATA   <= '0;
      count  <= '0;
      addr   <= '0;
    end else begin
      trig_q <= TRIGGER;
      case (state)
        IDLE: begin
          if (trig_edge) begin
            state <= SAMPLE;
            BUSY  <= 1'b1;
          end
        end
        SAMPLE: begin
          state <= CONVERT;
          count <= CNT_W'(DELAY_DEPTH - 1);
        end
        CONVERT: begin
          if (count == '0) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DATA  <= sample;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
`ifdef ADC_MOCK_DVALID_HOLD_EN
      if (done) begin
        DVALID <= 1'b1;
      end else if (enable) begin
        DVALID <= 1'b0;
      end
`else
      DVALID <= done;
`endif
      // A forced address overrides the completion increment.
      if (TB_FORCE_ADDR) begin
        addr <= TB_ADDR;
      end else if (done) begin
        addr <= addr + ADDR_DEPTH'(1);
      end
    end
  end

  // Converted word is captured once per conversion; no reset needed.
  always_ff @(posedge CLK) begin
    if (state == SAMPLE) begin
      sample <= TB_FORCE_DATA ? TB_DATA : pattern;
    end
  end

endmodule

// File: tb/tb_adc_mock_ctrl.sv
// Scoreboard bench for adc_mock_ctrl: reference model predicts conversions, monitor checks each DVALID.

module tb_adc_mock_ctrl;

  localparam int D = 5;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       TRIGGER = 1'b0;
  logic [7:0] DATA;
  logic       DVALID;
  logic       BUSY;
  logic       TB_FORCE_ADDR = 1'b0;
  logic       TB_FORCE_DATA = 1'b0;
  logic [7:0] TB_DATA = 8'h00;
  logic [7:0] TB_ADDR = 8'h00;

  adc_mock_ctrl #(.DELAY_DEPTH(D), .WORD_SIZE(8), .ADDR_DEPTH(8)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .TRIGGER       (TRIGGER),
    .DATA          (DATA),
    .DVALID        (DVALID),
    .BUSY          (BUSY),
    .TB_FORCE_ADDR (TB_FORCE_ADDR),
    .TB_FORCE_DATA (TB_FORCE_DATA),
    .TB_DATA       (TB_DATA),
    .TB_ADDR       (TB_ADDR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mcyc = 0;
  int   scyc = 0;

  // Reference model state
  int         m_rem = 0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_pat = 8'h00;
  logic [7:0] m_sample = 8'h00;
  logic       m_trig = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, scyc);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at that edge, then check outputs.
  task automatic tick();
    logic e;
    logic chk_pat;
    chk_pat = 1'b0;
    @(posedge CLK);
    scyc++;
    if (RESET) begin
      m_rem  = 0;
      m_addr = 8'h00;
      m_data = 8'h00;
      m_trig = 1'b0;
    end else begin
      e      = TRIGGER && !m_trig;
      m_trig = TRIGGER;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == D) begin
          m_sample = TB_FORCE_DATA ? TB_DATA : m_pat;
          chk_pat  = 1'b1;
        end
        if (m_rem == 0) begin
          m_data = m_sample;
          exp_q.push_back('{m_sample, scyc});
          m_addr = m_addr + 8'd1;
        end
      end else if (e) begin
        m_rem = D + 1;
        m_pat = m_addr ^ 8'hA5;
      end
      if (TB_FORCE_ADDR) m_addr = TB_ADDR;
    end
    #1;
    check("busy", 32'(BUSY), 32'(m_rem > 0));
    check("addr", 32'(dut.fake_adc_data.ADDR), 32'(m_addr));
    check("data_hold", 32'(DATA), 32'(m_data));
    if (chk_pat) check("pattern_probe", 32'(dut.fake_adc_data.DATA), 32'(m_pat));
  endtask

  task automatic convert_once();
    TRIGGER = 1'b1;
    tick();
    TRIGGER = 1'b0;
    repeat (D + 3) tick();
  endtask

  always @(posedge CLK) mcyc <= mcyc + 1;

  // Monitor: each new DVALID must match the oldest predicted conversion, in value and cycle.
  logic dv_prev = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (DVALID === 1'b1 && dv_prev !== 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL dvalid_unexpected: got DATA=%0h at cycle %0d, expected no DVALID", DATA, mcyc);
      end else begin
        e = exp_q.pop_front();
        if (DATA !== e.data || mcyc != e.cyc) begin
          miscompares++;
          $display("FAIL conversion: got DATA=%0h cycle %0d expected DATA=%0h cycle %0d",
                   DATA, mcyc, e.data, e.cyc);
        end
      end
    end
`ifndef ADC_MOCK_DVALID_HOLD_EN
    else if (dv_prev === 1'b1) begin
      vectors++;
      if (DVALID !== 1'b0) begin
        miscompares++;
        $display("FAIL dvalid_pulse: got %b expected 0 at cycle %0d", DVALID, mcyc);
      end
    end
`endif
    dv_prev = DVALID;
  end

  initial begin
    RESET = 1'b1;
    repeat (2) tick();
    RESET = 1'b0;
    check("reset_data", 32'(DATA), 32'h0);
    check("reset_dvalid", 32'(DVALID), 32'h0);
    check("reset_busy", 32'(BUSY), 32'h0);
    check("reset_addr", 32'(dut.fake_adc_data.ADDR), 32'h0);

    convert_once();
    check("first_data", 32'(DATA), 32'hA5);
    check("first_addr", 32'(dut.fake_adc_data.ADDR), 32'h1);

    convert_once();
    check("second_data", 32'(DATA), 32'hA4);

    // Retrigger while busy must be ignored.
    TRIGGER = 1'b1; tick();
    TRIGGER = 1'b0; tick();
    TRIGGER = 1'b1; tick();
    TRIGGER = 1'b0;
    repeat (D + 3) tick();
    check("busy_retrig_data", 32'(DATA), 32'hA7);
    check("busy_retrig_addr", 32'(dut.fake_adc_data.ADDR), 32'h3);

    TB_FORCE_ADDR = 1'b1; TB_ADDR = 8'hFF; tick();
    TB_FORCE_ADDR = 1'b0;
    convert_once();
    check("forced_addr_data", 32'(DATA), 32'h5A);
    convert_once();
    check("wrap_data", 32'(DATA), 32'hA5);
    check("wrap_addr", 32'(dut.fake_adc_data.ADDR), 32'h1);

    TB_FORCE_DATA = 1'b1; TB_DATA = 8'h3C;
    convert_once();
    check("forced_data", 32'(DATA), 32'h3C);
    TB_FORCE_DATA = 1'b0;

    // Abort in CONVERT.
    TRIGGER = 1'b1; tick();
    TRIGGER = 1'b0; repeat (3) tick();
    RESET = 1'b1; tick();
    RESET = 1'b0;
    check("abort_data", 32'(DATA), 32'h0);
    check("abort_dvalid", 32'(DVALID), 32'h0);
    check("abort_busy", 32'(BUSY), 32'h0);
    repeat (D + 3) tick();

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) TRIGGER = ~TRIGGER;
      TB_FORCE_ADDR = ($urandom_range(0, 15) == 0);
      TB_ADDR       = 8'($urandom);
      TB_FORCE_DATA = ($urandom_range(0, 3) == 0);
      TB_DATA       = 8'($urandom);
      RESET         = ($urandom_range(0, 99) == 0);
      tick();
    end

    RESET = 1'b0; TRIGGER = 1'b0; TB_FORCE_ADDR = 1'b0; TB_FORCE_DATA = 1'b0;
    repeat (D + 4) tick();
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
